// File: rtl/vga_scene_gen.sv
// Raster timing generator and scene renderer: bird, pipes, score ticks, ground and sky.
// Scene inputs are shadowed once per frame; the pixel path is two registered stages.
module vga_scene_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 29,
    parameter int NUM_PIPES = 2,
    parameter int SCORE_W   = 4,
    parameter int SYNC_POL  = 0
) (
    input  logic                    dclk,
    input  logic                    clr,
    input  logic [9:0]              bird_y,
    input  logic [NUM_PIPES*10-1:0] pipe_x,
    input  logic [NUM_PIPES*9-1:0]  pipe_gap,
    input  logic [SCORE_W-1:0]      score,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    de,
    output logic                    frame_start,
    output logic [2:0]              red,
    output logic [2:0]              green,
    output logic [1:0]              blue
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int TICKS   = (1 << SCORE_W) - 1;

    localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_PRE   = 11'(H_TOTAL - 2);
    localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
    localparam logic [10:0] HS_ON   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_OFF  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_ON   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_OFF  = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] GROUND  = 11'(V_ACTIVE - 20);
    localparam logic [10:0] TICK_Y0 = 11'(V_ACTIVE - 12);
    localparam logic [10:0] TICK_Y1 = 11'(V_ACTIVE - 2);
    localparam logic        POL     = (SYNC_POL != 0) ? 1'b1 : 1'b0;

    logic [10:0]             hc_r, vc_r;
    logic                    latch_s;
    logic [9:0]              bird_r;
    logic [NUM_PIPES*10-1:0] px_r;
    logic [NUM_PIPES*9-1:0]  gap_r;
    logic [SCORE_W-1:0]      score_r;

    logic [10:0] bird_ext_s, by_s, px_s, gp_s;
    logic        bird_hit_s, pipe_hit_s, tick_x_s, tick_s;

    logic [10:0] x1_r, y1_r;
    logic        v1_r, bird1_r, pipe1_r, tick1_r;

    logic        de_s, hs_act_s, vs_act_s, ground_s;
    logic [2:0]  red_s, green_s;
    logic [1:0]  blue_s;

    assign latch_s = (hc_r == H_LAST) && (vc_r == V_LAST);

    // Raster position counters.
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            hc_r <= 11'd0;
            vc_r <= 11'd0;
        end else if (hc_r == H_LAST) begin
            hc_r <= 11'd0;
            vc_r <= (vc_r == V_LAST) ? 11'd0 : vc_r + 11'd1;
        end else begin
            hc_r <= hc_r + 11'd1;
        end
    end

    // Frame-boundary shadow registers and frame_start pulse (high during the latch cycle).
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            bird_r      <= 10'd0;
            px_r        <= '0;
            gap_r       <= '0;
            score_r     <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= (hc_r == H_PRE) && (vc_r == V_LAST);
            if (latch_s) begin
                bird_r  <= bird_y;
                px_r    <= pipe_x;
                gap_r   <= pipe_gap;
                score_r <= score;
            end else begin
                bird_r  <= bird_r;
                px_r    <= px_r;
                gap_r   <= gap_r;
                score_r <= score_r;
            end
        end
    end

    // Object hit tests for the current raster position, all in 11 bits so nothing wraps.
    always_comb begin
        bird_ext_s = {1'b0, bird_r};
        by_s       = (bird_ext_s >= V_ACT) ? 11'd0 : (V_ACT - bird_ext_s);
        bird_hit_s = (hc_r >= 11'd100) && (hc_r < 11'd140) &&
                     ((vc_r + 11'd20) > by_s) && (vc_r < (by_s + 11'd20));
        px_s       = 11'd0;
        gp_s       = 11'd0;
        pipe_hit_s = 1'b0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            px_s       = {1'b0, px_r[10*i +: 10]};
            gp_s       = {2'b00, gap_r[9*i +: 9]};
            pipe_hit_s = pipe_hit_s |
                         ((hc_r >= px_s) && (hc_r < (px_s + 11'd50)) && (hc_r < H_ACT) &&
                          ((vc_r < gp_s) || (vc_r >= (gp_s + 11'd140))) && (vc_r < GROUND));
        end
        tick_x_s = 1'b0;
        for (int k = 0; k < TICKS; k++) begin
            tick_x_s = tick_x_s |
                       ((k < int'(score_r)) && (hc_r >= 11'(20 + 10 * k)) &&
                        (hc_r < 11'(25 + 10 * k)));
        end
        tick_s = tick_x_s && (vc_r >= TICK_Y0) && (vc_r <= TICK_Y1);
    end

    // Pixel stage 1: position, valid and hit flags.
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            x1_r    <= 11'd0;
            y1_r    <= 11'd0;
            v1_r    <= 1'b0;
            bird1_r <= 1'b0;
            pipe1_r <= 1'b0;
            tick1_r <= 1'b0;
        end else begin
            x1_r    <= hc_r;
            y1_r    <= vc_r;
            v1_r    <= 1'b1;
            bird1_r <= bird_hit_s;
            pipe1_r <= pipe_hit_s;
            tick1_r <= tick_s;
        end
    end

    // Stage 2 decode: sync/active windows and colour priority.
    always_comb begin
        de_s     = v1_r && (x1_r < H_ACT) && (y1_r < V_ACT);
        hs_act_s = (x1_r >= HS_ON) && (x1_r < HS_OFF);
        vs_act_s = (y1_r >= VS_ON) && (y1_r < VS_OFF);
        ground_s = (y1_r >= GROUND);
        red_s    = 3'd0;
        green_s  = 3'd0;
        blue_s   = 2'd0;
        if (!de_s) begin
            red_s = 3'd0; green_s = 3'd0; blue_s = 2'd0;
        end else if (tick1_r) begin
            red_s = 3'd7; green_s = 3'd7; blue_s = 2'd3;
        end else if (bird1_r) begin
            red_s = 3'd0; green_s = 3'd0; blue_s = 2'd0;
        end else if (pipe1_r) begin
            red_s = 3'd7; green_s = 3'd0; blue_s = 2'd0;
        end else if (ground_s) begin
            red_s = 3'd0; green_s = 3'd7; blue_s = 2'd0;
        end else begin
            red_s = 3'd0; green_s = 3'd7; blue_s = 2'd3;
        end
    end

    // Pixel stage 2: registered colour with syncs and de aligned to it.
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            hsync <= ~POL;
            vsync <= ~POL;
            de    <= 1'b0;
            red   <= 3'd0;
            green <= 3'd0;
            blue  <= 2'd0;
        end else begin
            hsync <= hs_act_s ? POL : ~POL;
            vsync <= vs_act_s ? POL : ~POL;
            de    <= de_s;
            red   <= red_s;
            green <= green_s;
            blue  <= blue_s;
        end
    end

endmodule

// File: tb/tb_vga_scene_gen.sv
// Scoreboard bench for vga_scene_gen on a reduced raster: probe pixels are queued
// with hand-computed colours and a monitor checks timing every cycle.
module tb_vga_scene_gen;

    localparam int HA = 160, HFP = 4, HS = 8, HBP = 4, HT = HA + HFP + HS + HBP;
    localparam int VA = 48,  VFP = 2, VS = 2, VBP = 3, VT = VA + VFP + VS + VBP;

    localparam logic [7:0] SKY = 8'b000_111_11;
    localparam logic [7:0] RED = 8'b111_000_00;
    localparam logic [7:0] GRN = 8'b000_111_00;
    localparam logic [7:0] BLK = 8'b000_000_00;
    localparam logic [7:0] WHT = 8'b111_111_11;

    logic        dclk = 1'b0;
    logic        clr  = 1'b1;
    logic [9:0]  bird_y = 10'd0;
    logic [19:0] pipe_x = 20'd0;
    logic [17:0] pipe_gap = 18'd0;
    logic [3:0]  score = 4'd0;
    logic        hsync, vsync, de, frame_start;
    logic [2:0]  red, green;
    logic [1:0]  blue;

    vga_scene_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .NUM_PIPES(2), .SCORE_W(4), .SYNC_POL(0)
    ) dut (
        .dclk(dclk), .clr(clr), .bird_y(bird_y), .pipe_x(pipe_x), .pipe_gap(pipe_gap),
        .score(score), .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start),
        .red(red), .green(green), .blue(blue)
    );

    always #5 dclk = ~dclk;

    typedef struct {
        int         x;
        int         y;
        logic [7:0] rgb;
    } probe_t;

    probe_t sb_q[$];
    int errors = 0;
    int checks = 0;

    // Reference raster: counter position and the pixel two stages behind it.
    int mh = 0, mv = 0, p1x = 0, p1y = 0, p2x = 0, p2y = 0;
    bit p1v = 1'b0, p2v = 1'b0;

    always @(posedge dclk or posedge clr) begin
        if (clr) begin
            mh <= 0; mv <= 0; p1x <= 0; p1y <= 0; p2x <= 0; p2y <= 0;
            p1v <= 1'b0; p2v <= 1'b0;
        end else begin
            p2x <= p1x; p2y <= p1y; p2v <= p1v;
            p1x <= mh;  p1y <= mv;  p1v <= 1'b1;
            if (mh == HT - 1) begin
                mh <= 0;
                mv <= (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh <= mh + 1;
            end
        end
    end

    logic       e_de, e_hs, e_vs, e_fs;
    logic [7:0] got_rgb;
    probe_t     pr;

    // Monitor: per-cycle timing check plus scoreboard pop on matching active pixels.
    always @(negedge dclk) begin
        e_de    = !clr && p2v && (p2x < HA) && (p2y < VA);
        e_hs    = !((p2x >= HA + HFP) && (p2x < HA + HFP + HS));
        e_vs    = !((p2y >= VA + VFP) && (p2y < VA + VFP + VS));
        e_fs    = !clr && (mh == HT - 1) && (mv == VT - 1);
        got_rgb = {red, green, blue};
        checks++;
        if ({hsync, vsync, de, frame_start} !== {e_hs, e_vs, e_de, e_fs} ||
            (!e_de && got_rgb !== 8'h00)) begin
            errors++;
            $display("FAIL timing pix(%0d,%0d) clr=%b: got hs,vs,de,fs=%b%b%b%b rgb=%h, want %b%b%b%b%s",
                     p2x, p2y, clr, hsync, vsync, de, frame_start, got_rgb,
                     e_hs, e_vs, e_de, e_fs, e_de ? "" : " rgb=00");
        end
        if (de === 1'b1 && sb_q.size() > 0 && sb_q[0].x == p2x && sb_q[0].y == p2y) begin
            pr = sb_q.pop_front();
            checks++;
            if (got_rgb !== pr.rgb) begin
                errors++;
                $display("FAIL pixel(%0d,%0d): got rgb=%h want %h", pr.x, pr.y, got_rgb, pr.rgb);
            end
        end
    end

    task automatic push(input int x, input int y, input logic [7:0] rgb);
        probe_t p;
        p.x = x; p.y = y; p.rgb = rgb;
        sb_q.push_back(p);
    endtask

    task automatic wait_frame_start();
        int n = 0;
        do begin
            @(negedge dclk);
            n++;
        end while (frame_start !== 1'b1 && n < HT * VT + 10);
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL frame_start_wait: got no pulse in %0d cycles, want one per %0d", n, HT * VT);
        end
    endtask

    task automatic wait_line(input int line);
        int n = 0;
        do begin
            @(negedge dclk);
            n++;
        end while (!(mv == line && mh == 0) && n < HT * VT + 10);
        checks++;
        if (!(mv == line && mh == 0)) begin
            errors++;
            $display("FAIL wait_line: got line %0d, want line %0d", mv, line);
        end
    endtask

    task automatic check_drained(input string tag);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drained_%s: got %0d unmatched probes (next at %0d,%0d), want 0",
                     tag, sb_q.size(), sb_q[0].x, sb_q[0].y);
            sb_q.delete();
        end
    endtask

    initial begin
        repeat (4) @(negedge dclk);
        #1 clr = 1'b0;

        // Frame A: shadows still zero; inputs for frame B are applied mid-frame.
        push(0, 0, SKY);    push(120, 10, SKY); push(159, 27, SKY); push(120, 28, GRN);
        push(120, 29, BLK); push(99, 40, GRN);  push(100, 40, BLK); push(139, 47, BLK);
        push(140, 47, GRN);
        bird_y   = 10'd24;
        pipe_x   = {10'd15, 10'd140};
        pipe_gap = {9'd30, 9'd10};
        score    = 4'd3;
        wait_frame_start();
        check_drained("a");

        // Frame B: bird at by=24, pipes at 140 (gap 10) and 15 (gap 30), three ticks.
        push(14, 0, SKY);   push(15, 0, RED);   push(64, 0, RED);   push(65, 0, SKY);
        push(120, 4, SKY);  push(140, 4, RED);  push(120, 5, BLK);  push(150, 5, RED);
        push(159, 9, RED);  push(150, 10, SKY); push(30, 20, RED);  push(150, 20, SKY);
        push(120, 27, BLK); push(30, 28, GRN);  push(19, 36, GRN);  push(20, 36, WHT);
        push(24, 36, WHT);  push(25, 36, GRN);  push(22, 40, WHT);  push(50, 40, GRN);
        push(150, 40, GRN); push(120, 43, BLK); push(120, 44, GRN); push(44, 46, WHT);
        push(44, 47, GRN);
        @(posedge dclk);
        #1;
        bird_y = 10'd1000;
        pipe_x = {10'd1023, 10'd200};
        score  = 4'd0;
        wait_frame_start();
        check_drained("b");

        // Frame C: clamped bird, invisible pipes; inputs change at line 20 without effect.
        push(120, 0, BLK);  push(99, 5, SKY);   push(120, 5, BLK);  push(139, 19, BLK);
        push(120, 20, SKY); push(10, 25, SKY);  push(120, 30, GRN); push(22, 40, GRN);
        push(120, 47, GRN); push(159, 47, GRN);
        wait_line(20);
        bird_y = 10'd0;
        score  = 4'd15;
        wait_frame_start();
        check_drained("c");

        // Frame D: fifteen ticks over a low bird, then a mid-frame clear.
        push(120, 10, SKY); push(120, 30, BLK); push(22, 35, GRN);  push(20, 36, WHT);
        push(115, 36, BLK); push(120, 36, WHT); push(150, 36, WHT); push(155, 36, GRN);
        push(159, 36, GRN); push(144, 40, WHT); push(145, 40, GRN);
        wait_line(45);
        check_drained("d");
        #1 clr = 1'b1;
        repeat (3) @(negedge dclk);
        #1 clr = 1'b0;

        // Frame E: restarted raster with zeroed shadows despite nonzero inputs.
        push(0, 0, SKY);    push(120, 30, BLK); push(22, 40, GRN);  push(120, 40, BLK);
        push(159, 47, GRN);
        wait_frame_start();
        check_drained("e");

        repeat (5) @(negedge dclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
